// File: rtl/aclk_pkg.sv
// Shared time types and limits for the alarm clock timekeeping and alarm stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aclk_pkg;

    typedef logic [4:0] hour_t;
    typedef logic [5:0] min_t;
    typedef logic [5:0] sec_t;

    localparam hour_t MAX_HOUR = 5'd23;
    localparam min_t  MAX_MIN  = 6'd59;
    localparam sec_t  MAX_SEC  = 6'd59;

    typedef struct packed {
        hour_t hour;
        min_t  min;
        sec_t  sec;
    } aclk_time_t;

    // True when an H:M pair is a legal time of day.
    function automatic logic hm_valid(input hour_t h, input min_t m);
        return (h <= MAX_HOUR) && (m <= MAX_MIN);
    endfunction

endpackage

// File: rtl/aclk_timekeeper_if.sv
// Load request and time/alarm status bundle between the controller and the timekeeper.
// Latency: n/a (wires only).
// Backpressure: none; loads are level-sensitive, one load per cycle held high.
// Ports: LD_time/LD_alarm/H_in/M_in flow master->slave; time, alarm, sec_tick,
// match and ld_err flow slave->master.
interface aclk_timekeeper_if;
    import aclk_pkg::*;

    logic  LD_time;
    logic  LD_alarm;
    hour_t H_in;
    min_t  M_in;
    hour_t hours;
    min_t  minutes;
    sec_t  seconds;
    hour_t al_hours;
    min_t  al_minutes;
    logic  sec_tick;
    logic  match;
    logic  ld_err;

    modport master (
        output LD_time, LD_alarm, H_in, M_in,
        input  hours, minutes, seconds, al_hours, al_minutes, sec_tick, match, ld_err
    );

    modport slave (
        input  LD_time, LD_alarm, H_in, M_in,
        output hours, minutes, seconds, al_hours, al_minutes, sec_tick, match, ld_err
    );

endinterface

// File: rtl/aclk_prescaler.sv
// Divides clk down to one advance strobe every TICKS_PER_SEC cycles.
// Latency: adv is high during the cycle the counter sits at TICKS_PER_SEC-1.
// Backpressure: none; clear forces the count back to 0 and wins over counting.
// Ports: clk, rst_n (async active-low), clear (restart the second), adv (advance strobe).
module aclk_prescaler #(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic adv
);

    localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    assign adv = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || adv) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/aclk_timekeeper.sv
// Keeps hh:mm:ss from the prescaler strobe, holds the alarm time and flags alarm hits.
// Latency: all outputs registered; loads and ld_err appear one edge after sampling.
// Backpressure: none; a load overrides the same-cycle advance, illegal loads are dropped.
// Ports: clk, rst_n (async active-low), tk (slave side of aclk_timekeeper_if).
module aclk_timekeeper
    import aclk_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    aclk_timekeeper_if.slave   tk
);

    aclk_time_t cur_q;
    aclk_time_t nxt;
    hour_t      al_hour_q;
    min_t       al_min_q;
    logic       sec_tick_q;
    logic       match_q;
    logic       ld_err_q;

    logic       adv;
    logic       ld_ok;
    logic       time_ld;
    logic       al_ld;
    logic       adv_eff;
    logic       hit;

    assign ld_ok   = hm_valid(tk.H_in, tk.M_in);
    assign time_ld = tk.LD_time  && ld_ok;
    assign al_ld   = tk.LD_alarm && ld_ok;
    // A time load restarts the second, so it swallows any advance due this edge.
    assign adv_eff = adv && !time_ld;

    aclk_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (time_ld),
        .adv   (adv)
    );

    // Incremented time with the full carry chain resolved in one edge.
    always_comb begin
        nxt = cur_q;
        if (cur_q.sec == MAX_SEC) begin
            nxt.sec = '0;
            if (cur_q.min == MAX_MIN) begin
                nxt.min = '0;
                if (cur_q.hour == MAX_HOUR) nxt.hour = '0;
                else                        nxt.hour = cur_q.hour + hour_t'(1);
            end else begin
                nxt.min = cur_q.min + min_t'(1);
            end
        end else begin
            nxt.sec = cur_q.sec + sec_t'(1);
        end
    end

    // Compared on the incremented value, so only a genuine rollover into hh:mm:00 hits;
    // reloading the alarm to the current hh:mm mid-minute cannot trigger it.
    assign hit = (nxt.sec == '0) && (nxt.hour == al_hour_q) && (nxt.min == al_min_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= '0;
            al_hour_q  <= '0;
            al_min_q   <= '0;
            sec_tick_q <= 1'b0;
            match_q    <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            sec_tick_q <= adv_eff;
            match_q    <= adv_eff && hit;
            ld_err_q   <= (tk.LD_time || tk.LD_alarm) && !ld_ok;

            if (time_ld) begin
                cur_q.hour <= tk.H_in;
                cur_q.min  <= tk.M_in;
                cur_q.sec  <= '0;
            end else if (adv) begin
                cur_q <= nxt;
            end

            if (al_ld) begin
                al_hour_q <= tk.H_in;
                al_min_q  <= tk.M_in;
            end
        end
    end

    assign tk.hours      = cur_q.hour;
    assign tk.minutes    = cur_q.min;
    assign tk.seconds    = cur_q.sec;
    assign tk.al_hours   = al_hour_q;
    assign tk.al_minutes = al_min_q;
    assign tk.sec_tick   = sec_tick_q;
    assign tk.match      = match_q;
    assign tk.ld_err     = ld_err_q;

endmodule

// File: doc/aclk_timekeeper.md
# aclk_timekeeper

Real-time timekeeping core of the alarm clock. Divides the 10 Hz system clock into a 1 Hz second tick and maintains hours/minutes/seconds. Holds the programmed alarm time and issues a one-cycle match pulse when the running time reaches it. Sits directly upstream of the alarm-operation stage, which qualifies the match with AL_ON/STOP_al and drives Alarm.

## Interface

Parameters:
- TICKS_PER_SEC, default 10: clk cycles per second (must be ≥2).

Ports:
- clk  in  1  10 Hz system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- LD_time  in  1  load H_in:M_in into current time; seconds and prescaler cleared.
- LD_alarm  in  1  load H_in:M_in into alarm registers.
- H_in  in  5  hour value to load, 0–23.
- M_in  in  6  minute value to load, 0–59.
- hours  out  5  current hour, 0–23.
- minutes  out  6  current minute, 0–59.
- seconds  out  6  current second, 0–59.
- al_hours  out  5  stored alarm hour.
- al_minutes  out  6  stored alarm minute.
- sec_tick  out  1  one-cycle pulse in the cycle seconds takes a new counted value.
- match  out  1  one-cycle pulse when counted time reaches al_hours:al_minutes:00.
- ld_err  out  1  one-cycle pulse when a load is rejected.

## Operation

- Reset (rst_n low, asynchronous): prescaler 0, time 00:00:00, alarm 00:00, sec_tick/match/ld_err 0.
- Prescaler: counts 0..TICKS_PER_SEC-1, wraps to 0. Advance condition = prescaler at TICKS_PER_SEC-1.
- On advance: seconds+1; 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0. Full wrap 23:59:59→00:00:00 in one edge.
- match: asserted in the same cycle the advance produces seconds=0 with hours:minutes equal to alarm (compare computed on next-state values, registered). Never asserted by a load, never by reset.
- Load validation: H_in>23 or M_in>59 rejects the load (targeted registers unchanged), ld_err pulses next cycle.
- LD_time (valid): hours←H_in, minutes←M_in, seconds←0, prescaler←0. Suppresses that cycle's advance; no sec_tick, no match.
- LD_alarm (valid): alarm registers updated; time counting unaffected.
- LD_time and LD_alarm together: both loaded from the same H_in:M_in; match not generated.
- Alarm reload equal to current hh:mm mid-minute: no match until the next genuine rollover to that hh:mm:00 (i.e. 24 h later).
- Load inputs are level; held high for N cycles = N loads (prescaler held at 0 while LD_time high).

## Timing

- All outputs registered; no combinational input-to-output path.
- First advance after reset release: on the TICKS_PER_SEC-th rising edge; seconds=1 and sec_tick=1 from that edge for one cycle.
- After LD_time on edge k, next advance on edge k+TICKS_PER_SEC.
- Load visible on outputs one edge after sampling; ld_err same edge.
- sec_tick and match are exactly one clk cycle wide; match only coincides with sec_tick.

## Structure

- Package aclk_pkg: MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59; typedef hour_t (logic[4:0]), min_t/sec_t (logic[5:0]); struct aclk_time_t {hour, min, sec}. Shared with the alarm-operation stage.
- One sub-module: aclk_prescaler (parameter TICKS_PER_SEC; inputs clk, rst_n, clear; output adv). Carry chain, load logic and match compare stay in aclk_timekeeper.

## Test plan

- Reset then 10 clk edges -> seconds=1, sec_tick high exactly one cycle; 600 edges -> 00:01:00.
- LD_time H_in=23, M_in=59, run 600 edges -> 00:00:00 at the 600th, carries in one edge, no glitch values.
- LD_alarm 07:30, LD_time 07:29, run 600 edges -> match one cycle with time 07:30:00 and sec_tick high; no further match over the next 600 edges.
- LD_time H_in=24 M_in=10 -> ld_err one cycle, time unchanged; LD_alarm M_in=60 -> ld_err, alarm unchanged.
- LD_time 12:00 asserted on the prescaler-wrap edge -> time 12:00:00, no sec_tick, no match even with alarm 12:00; next advance 10 edges later.
- rst_n low mid-count at 05:05:37 -> all outputs zero immediately, asynchronously; resumes from 00:00:00 with first sec_tick 10 edges after release.
